// File: rtl/vga_field_renderer_pkg.sv
// Shared defaults, slot type and span helper for the VGA field renderer.
// Optional blinking support is enabled with the VGA_FIELD_BLINK_EN macro.
package vga_field_renderer_pkg;

    localparam int unsigned DefHActive     = 640;
    localparam int unsigned DefVActive     = 480;
    localparam int unsigned DefFieldXBegin = 16;
    localparam int unsigned DefFieldXEnd   = 623;
    localparam int unsigned DefFieldYBegin = 16;
    localparam int unsigned DefFieldYEnd   = 463;
    localparam int unsigned DefNumObj      = 4;
    localparam int unsigned DefObjSize     = 16;
    localparam int unsigned DefBlinkFrames = 16;
    localparam logic [7:0]  DefBorderRgb   = 8'b000_100_01;
    localparam logic [7:0]  DefFieldRgb    = 8'b000_000_00;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] rgb;
        logic       valid;
        logic       blink;
    } obj_slot_t;

    // Widened to 11 bits so an object placed near coordinate 1023 does not wrap.
    function automatic logic in_span(logic [9:0] v, logic [9:0] lo, int unsigned size);
        logic [10:0] hi;
        hi = {1'b0, lo} + 11'(size);
        return ({1'b0, v} >= {1'b0, lo}) && ({1'b0, v} < hi);
    endfunction

endpackage

// File: rtl/vga_field_renderer_if.sv
// Object-update bus between game logic (master) and the field renderer (slave).
// Optional blinking support is enabled with the VGA_FIELD_BLINK_EN macro.
interface vga_field_renderer_if
    import vga_field_renderer_pkg::*;
#(
    parameter int unsigned NUM_OBJ = DefNumObj
);

    logic [10*NUM_OBJ-1:0] obj_x;
    logic [10*NUM_OBJ-1:0] obj_y;
    logic [8*NUM_OBJ-1:0]  obj_rgb;
    logic [NUM_OBJ-1:0]    obj_valid;
    logic [NUM_OBJ-1:0]    obj_blink;
    logic                  obj_update;
    logic                  obj_pending;
    logic                  obj_ack;

    modport master (
        output obj_x, obj_y, obj_rgb, obj_valid, obj_blink, obj_update,
        input  obj_pending, obj_ack
    );

    modport slave (
        input  obj_x, obj_y, obj_rgb, obj_valid, obj_blink, obj_update,
        output obj_pending, obj_ack
    );

endinterface

// File: rtl/vga_obj_hit.sv
// Registered rectangle hit test of the current scan position against one object slot.
// Optional blinking support (VGA_FIELD_BLINK_EN) is resolved by the caller via en_i.
module vga_obj_hit
    import vga_field_renderer_pkg::*;
#(
    parameter int unsigned OBJ_SIZE = DefObjSize
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x_i,
    input  logic [9:0] y_i,
    input  logic [9:0] ox_i,
    input  logic [9:0] oy_i,
    input  logic       en_i,
    output logic       hit_o
);

    logic hit_d;
    logic hit_q;

    always_comb begin
        hit_d = en_i && in_span(x_i, ox_i, OBJ_SIZE) && in_span(y_i, oy_i, OBJ_SIZE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign hit_o = hit_q;

endmodule

// File: rtl/vga_field_renderer.sv
// Two-stage pixel colour generator: blanking, border, double-buffered objects, background.
// Define VGA_FIELD_BLINK_EN to let slots with obj_blink=1 blink on a frame-count phase.
module vga_field_renderer
    import vga_field_renderer_pkg::*;
#(
    parameter int unsigned H_ACTIVE      = DefHActive,
    parameter int unsigned V_ACTIVE      = DefVActive,
    parameter int unsigned FIELD_X_BEGIN = DefFieldXBegin,
    parameter int unsigned FIELD_X_END   = DefFieldXEnd,
    parameter int unsigned FIELD_Y_BEGIN = DefFieldYBegin,
    parameter int unsigned FIELD_Y_END   = DefFieldYEnd,
    parameter int unsigned NUM_OBJ       = DefNumObj,
    parameter int unsigned OBJ_SIZE      = DefObjSize,
    parameter logic [7:0]  BORDER_RGB    = DefBorderRgb,
    parameter logic [7:0]  FIELD_RGB     = DefFieldRgb,
    parameter int unsigned BLINK_FRAMES  = DefBlinkFrames
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [9:0]           CounterX,
    input  logic [9:0]           CounterY,
    vga_field_renderer_if.slave  obj_bus,
    output logic [7:0]           frame_cnt,
    output logic [2:0]           r,
    output logic [2:0]           g,
    output logic [1:0]           b
);

    localparam logic [9:0] HAct    = 10'(H_ACTIVE);
    localparam logic [9:0] VAct    = 10'(V_ACTIVE);
    localparam logic [9:0] FxBegin = 10'(FIELD_X_BEGIN);
    localparam logic [9:0] FxEnd   = 10'(FIELD_X_END);
    localparam logic [9:0] FyBegin = 10'(FIELD_Y_BEGIN);
    localparam logic [9:0] FyEnd   = 10'(FIELD_Y_END);

    obj_slot_t          stage_d  [NUM_OBJ];
    obj_slot_t          stage_q  [NUM_OBJ];
    obj_slot_t          active_d [NUM_OBJ];
    obj_slot_t          active_q [NUM_OBJ];
    logic               pending_d, pending_q;
    logic               ack_d, ack_q;
    logic [7:0]         frame_cnt_d, frame_cnt_q;
    logic               act_d, act_q;
    logic               border_d, border_q;
    logic               in_vb_d, in_vb_q;
    logic               in_vb_prev_d, in_vb_prev_q;
    logic               vb_start;
    logic [7:0]         rgb_d, rgb_q;
    logic [NUM_OBJ-1:0] hit_q;
    logic [NUM_OBJ-1:0] slot_vis;

    // Stage 1 flags; the rising edge of the registered vblank flag fires once per frame.
    always_comb begin
        act_d        = (CounterX < HAct) && (CounterY < VAct);
        border_d     = (CounterX < FxBegin) || (CounterX > FxEnd) ||
                       (CounterY < FyBegin) || (CounterY > FyEnd);
        in_vb_d      = (CounterY >= VAct);
        in_vb_prev_d = in_vb_q;
    end

    assign vb_start = in_vb_q && !in_vb_prev_q;

    // Commit reads the old staging set, so a same-cycle update stays pending.
    always_comb begin
        stage_d     = stage_q;
        active_d    = active_q;
        pending_d   = pending_q;
        ack_d       = 1'b0;
        frame_cnt_d = frame_cnt_q;
        if (vb_start) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            if (pending_q) begin
                active_d  = stage_q;
                ack_d     = 1'b1;
                pending_d = 1'b0;
            end
        end
        if (obj_bus.obj_update) begin
            for (int unsigned i = 0; i < NUM_OBJ; i++) begin
                stage_d[i].x     = obj_bus.obj_x[10*i +: 10];
                stage_d[i].y     = obj_bus.obj_y[10*i +: 10];
                stage_d[i].rgb   = obj_bus.obj_rgb[8*i +: 8];
                stage_d[i].valid = obj_bus.obj_valid[i];
                stage_d[i].blink = obj_bus.obj_blink[i];
            end
            pending_d = 1'b1;
        end
    end

`ifdef VGA_FIELD_BLINK_EN
    logic blink_on;

    assign blink_on = ((32'(frame_cnt_q) / BLINK_FRAMES) % 32'd2) == 32'd0;

    always_comb begin
        slot_vis = '0;
        for (int unsigned i = 0; i < NUM_OBJ; i++) begin
            slot_vis[i] = !active_q[i].blink || blink_on;
        end
    end
`else
    logic [NUM_OBJ-1:0] unused_blink;
    logic               unused_blink_cfg;

    assign slot_vis         = '1;
    assign unused_blink_cfg = BLINK_FRAMES[0];

    always_comb begin
        unused_blink = '0;
        for (int unsigned i = 0; i < NUM_OBJ; i++) begin
            unused_blink[i] = active_q[i].blink;
        end
    end
`endif

    for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_hit
        vga_obj_hit #(
            .OBJ_SIZE(OBJ_SIZE)
        ) u_hit (
            .clk  (clk),
            .reset(reset),
            .x_i  (CounterX),
            .y_i  (CounterY),
            .ox_i (active_q[gi].x),
            .oy_i (active_q[gi].y),
            .en_i (active_q[gi].valid && slot_vis[gi]),
            .hit_o(hit_q[gi])
        );
    end

    // Stage 2 priority: blank, border, lowest-index hit, background.
    always_comb begin
        logic hit_any;
        hit_any = 1'b0;
        rgb_d   = FIELD_RGB;
        for (int unsigned i = 0; i < NUM_OBJ; i++) begin
            if (hit_q[i] && !hit_any) begin
                rgb_d   = active_q[i].rgb;
                hit_any = 1'b1;
            end
        end
        if (border_q) begin
            rgb_d = BORDER_RGB;
        end
        if (!act_q) begin
            rgb_d = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_OBJ; i++) begin
                stage_q[i]  <= '0;
                active_q[i] <= '0;
            end
            pending_q    <= 1'b0;
            ack_q        <= 1'b0;
            frame_cnt_q  <= 8'd0;
            act_q        <= 1'b0;
            border_q     <= 1'b0;
            in_vb_q      <= 1'b0;
            in_vb_prev_q <= 1'b0;
            rgb_q        <= 8'h00;
        end else begin
            stage_q      <= stage_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            ack_q        <= ack_d;
            frame_cnt_q  <= frame_cnt_d;
            act_q        <= act_d;
            border_q     <= border_d;
            in_vb_q      <= in_vb_d;
            in_vb_prev_q <= in_vb_prev_d;
            rgb_q        <= rgb_d;
        end
    end

    assign obj_bus.obj_pending = pending_q;
    assign obj_bus.obj_ack     = ack_q;
    assign frame_cnt           = frame_cnt_q;
    assign {r, g, b}           = rgb_q;

endmodule

// File: tb/tb_vga_field_renderer.sv
// Randomised bench for vga_field_renderer against a frame-level reference model.
// Build with +define+VGA_FIELD_BLINK_EN to cover the blinking variant.
module tb_vga_field_renderer;

    localparam int NO = 4;
    localparam int BF = 2;
    localparam logic [7:0] BORDER = 8'h11;
    localparam logic [7:0] FIELD  = 8'h00;

    typedef struct {
        int x;
        int y;
        int rgb;
        bit v;
        bit bl;
    } slot_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] CounterX;
    logic [9:0] CounterY;
    logic [7:0] frame_cnt;
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;

    vga_field_renderer_if #(.NUM_OBJ(NO)) obj_bus ();

    vga_field_renderer #(
        .NUM_OBJ     (NO),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .CounterX (CounterX),
        .CounterY (CounterY),
        .obj_bus  (obj_bus),
        .frame_cnt(frame_cnt),
        .r        (r),
        .g        (g),
        .b        (b)
    );

    always #20 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    slot_t u   [NO];  // next values to present on the bus
    slot_t m_s [NO];  // model staging set
    slot_t m_a [NO];  // model displayed set
    bit    m_pending;
    int    m_frame;
    logic [7:0] blink_exp [4];

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit phase_on();
`ifdef VGA_FIELD_BLINK_EN
        return ((m_frame / BF) % 2) == 0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [7:0] model_rgb(int x, int y);
        if (x >= 640 || y >= 480) return 8'h00;
        if (x < 16 || x > 623 || y < 16 || y > 463) return BORDER;
        for (int i = 0; i < NO; i++) begin
            if (m_a[i].v && (!m_a[i].bl || phase_on()) &&
                x >= m_a[i].x && x < m_a[i].x + 16 && y >= m_a[i].y && y < m_a[i].y + 16)
                return 8'(m_a[i].rgb);
        end
        return FIELD;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NO; i++) begin
            m_s[i] = '{0, 0, 0, 1'b0, 1'b0};
            m_a[i] = '{0, 0, 0, 1'b0, 1'b0};
        end
        m_pending = 1'b0;
        m_frame   = 0;
    endtask

    task automatic clear_slots();
        for (int i = 0; i < NO; i++) u[i] = '{0, 0, 0, 1'b0, 1'b0};
    endtask

    task automatic drive_bus();
        for (int i = 0; i < NO; i++) begin
            obj_bus.obj_x[10*i +: 10] = 10'(u[i].x);
            obj_bus.obj_y[10*i +: 10] = 10'(u[i].y);
            obj_bus.obj_rgb[8*i +: 8] = 8'(u[i].rgb);
            obj_bus.obj_valid[i]      = u[i].v;
            obj_bus.obj_blink[i]      = u[i].bl;
        end
    endtask

    task automatic check_pixel(string tag, int x, int y, logic [7:0] exp);
        CounterX = 10'(x);
        CounterY = 10'(y);
        repeat (2) @(posedge clk);
        #1 check_eq(tag, {24'd0, r, g, b}, {24'd0, exp});
    endtask

    task automatic do_update();
        drive_bus();
        obj_bus.obj_update = 1'b1;
        @(posedge clk);
        #1 obj_bus.obj_update = 1'b0;
        m_s       = u;
        m_pending = 1'b1;
        check_eq("pending_set", {31'd0, obj_bus.obj_pending}, 32'd1);
    endtask

    // Enters vertical blank from an active row; optionally strobes an update in the entry cycle.
    task automatic do_vblank(bit upd);
        bit exp_ack;
        CounterX = 10'd320;
        CounterY = 10'd240;
        @(posedge clk);
        #1 CounterX = 10'd0;
        CounterY = 10'd490;
        @(posedge clk);
        #1 check_eq("ack_early", {31'd0, obj_bus.obj_ack}, 32'd0);
        if (upd) begin
            drive_bus();
            obj_bus.obj_update = 1'b1;
        end
        exp_ack = m_pending;
        m_frame = (m_frame + 1) % 256;
        if (m_pending) begin
            m_a       = m_s;
            m_pending = 1'b0;
        end
        if (upd) begin
            m_s       = u;
            m_pending = 1'b1;
        end
        @(posedge clk);
        #1 obj_bus.obj_update = 1'b0;
        check_eq("ack", {31'd0, obj_bus.obj_ack}, {31'd0, exp_ack});
        check_eq("pending_vb", {31'd0, obj_bus.obj_pending}, {31'd0, m_pending});
        check_eq("frame_cnt", {24'd0, frame_cnt}, 32'(m_frame));
        @(posedge clk);
        #1 check_eq("ack_once", {31'd0, obj_bus.obj_ack}, 32'd0);
        repeat (3) @(posedge clk);
        #1 check_eq("frame_stall", {24'd0, frame_cnt}, 32'(m_frame));
    endtask

    task automatic rand_slots();
        for (int i = 0; i < NO; i++) begin
            u[i].x   = int'($urandom_range(0, 1023));
            u[i].y   = int'($urandom_range(0, 479));
            if ($urandom_range(0, 3) != 0) u[i].x = int'($urandom_range(0, 639));
            u[i].rgb = int'($urandom_range(0, 255));
            u[i].v   = ($urandom_range(0, 3) != 0);
            u[i].bl  = $urandom_range(0, 1) == 1;
        end
    endtask

    task automatic rand_pixels(int n);
        int x;
        int y;
        int s;
        for (int k = 0; k < n; k++) begin
            if (k % 2 == 0) begin
                s = int'($urandom_range(0, NO - 1));
                x = m_a[s].x + int'($urandom_range(0, 19)) - 2;
                y = m_a[s].y + int'($urandom_range(0, 19)) - 2;
            end else begin
                x = int'($urandom_range(0, 799));
                y = int'($urandom_range(0, 479));
            end
            if (x < 0) x = 0;
            if (x > 1023) x = 1023;
            if (y < 0) y = 0;
            if (y > 479) y = 479;
            check_pixel("rand_px", x, y, model_rgb(x, y));
        end
    endtask

    initial begin
`ifdef VGA_FIELD_BLINK_EN
        blink_exp = '{8'h00, 8'h00, 8'hE0, 8'hE0};
`else
        blink_exp = '{8'hE0, 8'hE0, 8'hE0, 8'hE0};
`endif
        reset              = 1'b1;
        CounterX           = 10'd700;
        CounterY           = 10'd10;
        obj_bus.obj_x      = '0;
        obj_bus.obj_y      = '0;
        obj_bus.obj_rgb    = '0;
        obj_bus.obj_valid  = '0;
        obj_bus.obj_blink  = '0;
        obj_bus.obj_update = 1'b0;
        clear_slots();
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Dirty the state, then reset mid-frame while showing a border pixel.
        check_pixel("border_pre", 5, 100, BORDER);
        u[0] = '{300, 300, 8'hE0, 1'b1, 1'b0};
        do_update();
        do_vblank(1'b0);
        check_pixel("obj_pre_rst", 305, 305, 8'hE0);
        u[0] = '{50, 50, 8'h1C, 1'b1, 1'b0};
        do_update();
        CounterX = 10'd5;
        CounterY = 10'd100;
        reset    = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1 check_eq("rst_rgb", {24'd0, r, g, b}, 32'd0);
        end
        CounterX = 10'd700;
        CounterY = 10'd10;
        reset    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_eq("rst_rgb_post", {24'd0, r, g, b}, 32'd0);
        check_eq("rst_frame", {24'd0, frame_cnt}, 32'd0);
        check_eq("rst_pending", {31'd0, obj_bus.obj_pending}, 32'd0);
        check_pixel("rst_active_clr", 305, 305, FIELD);
        do_vblank(1'b0);

        // Blink phase over frames 2..5; slot1 never blinks.
        clear_slots();
        u[0] = '{300, 300, 8'hE0, 1'b1, 1'b1};
        u[1] = '{400, 300, 8'h1C, 1'b1, 1'b0};
        do_update();
        for (int f = 0; f < 4; f++) begin
            do_vblank(1'b0);
            check_pixel("blink_slot", 305, 305, blink_exp[f]);
            check_pixel("steady_slot", 405, 305, 8'h1C);
        end

        // Two-cycle latency with back-to-back pixels.
        clear_slots();
        do_update();
        do_vblank(1'b0);
        check_pixel("blank", 700, 10, 8'h00);
        check_pixel("field", 320, 240, FIELD);
        CounterX = 10'd700;
        CounterY = 10'd10;
        repeat (2) @(posedge clk);
        #1 CounterX = 10'd5;
        CounterY = 10'd100;
        @(posedge clk);
        #1 check_eq("pipe_lat1", {24'd0, r, g, b}, 32'd0);
        CounterX = 10'd320;
        CounterY = 10'd240;
        @(posedge clk);
        #1 check_eq("pipe_a", {24'd0, r, g, b}, {24'd0, BORDER});
        CounterX = 10'd5;
        CounterY = 10'd100;
        @(posedge clk);
        #1 check_eq("pipe_b", {24'd0, r, g, b}, {24'd0, FIELD});
        @(posedge clk);
        #1 check_eq("pipe_c", {24'd0, r, g, b}, {24'd0, BORDER});

        // Update mid-frame is invisible until vblank commits it.
        u[0] = '{100, 100, 8'hE0, 1'b1, 1'b0};
        do_update();
        check_pixel("t3_before", 105, 105, FIELD);
        do_vblank(1'b0);
        check_pixel("t3_hit", 105, 105, 8'hE0);
        check_pixel("t3_edge_in", 115, 115, 8'hE0);
        check_pixel("t3_edge_out", 116, 105, FIELD);

        // Overlap priority and objects under the border.
        u[0] = '{192, 192, 8'hE0, 1'b1, 1'b0};
        u[1] = '{195, 195, 8'h1C, 1'b1, 1'b0};
        u[2] = '{8, 100, 8'hFF, 1'b1, 1'b0};
        u[3] = '{400, 400, 8'h03, 1'b0, 1'b0};
        do_update();
        do_vblank(1'b0);
        check_pixel("t4_prio", 200, 200, 8'hE0);
        check_pixel("t4_slot1", 210, 210, 8'h1C);
        check_pixel("t4_border", 10, 105, BORDER);
        check_pixel("t4_in_field", 20, 105, 8'hFF);
        check_pixel("t4_invalid", 405, 405, FIELD);

        // Update in the vblank-entry cycle: old set commits, new set waits a frame.
        clear_slots();
        u[0] = '{250, 250, 8'h1C, 1'b1, 1'b0};
        do_update();
        u[0] = '{250, 250, 8'hE3, 1'b1, 1'b0};
        do_vblank(1'b1);
        check_eq("t5_pending", {31'd0, obj_bus.obj_pending}, 32'd1);
        check_pixel("t5_old", 255, 255, 8'h1C);
        do_vblank(1'b0);
        check_pixel("t5_new", 255, 255, 8'hE3);

        for (int it = 0; it < 50; it++) begin
            int nupd;
            nupd = int'($urandom_range(0, 2));
            for (int k = 0; k < nupd; k++) begin
                rand_slots();
                do_update();
            end
            rand_slots();
            do_vblank($urandom_range(0, 3) == 0);
            rand_pixels(10);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
